// File: rtl/spi_tx16.sv
// spi_tx16 -- 16-bit SPI mode-0 frame transmitter with 2-bit address lines.
// Frame: SETUP, 16 bits of SHIFT (high then low half-period each), HOLD, GAP.
// Every non-IDLE state is timed by an 8-bit divider counting CLK_DIV cycles.
// Optional feature: define SPI_TX_MISO_EN to add spi_miso / rx_data capture.
module spi_tx16 #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] tx_data,
  input  logic [1:0]  tx_addr,
  output logic        busy,
  output logic        done,
  output logic        spi_cs,
  output logic        spi_clk,
  output logic        spi_mosi,
  output logic [1:0]  spi_a
`ifdef SPI_TX_MISO_EN
  ,
  input  logic        spi_miso,
  output logic [15:0] rx_data
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state;
  logic [7:0]  div_cnt;
  logic [3:0]  bit_cnt;
  logic [15:0] shreg;
  logic        div_end;

`ifdef SPI_TX_MISO_EN
  logic [15:0] rx_shift;
`endif

  assign div_end = (div_cnt == DIV_LAST);

  // Frame sequencer: state, divider, bit counter, shifter and all outputs.
  always_ff @(posedge clk) begin
    // NOTE: every register here is state, so non-blocking assignments only;
    // blocking would let later statements see this cycle's new values.
    if (reset) begin
      // NOTE: synchronous reset covers every register, including the data
      // shifter, so an aborted frame leaves nothing stale behind.
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      spi_cs   <= 1'b1;
      spi_clk  <= 1'b0;
      spi_mosi <= 1'b0;
      spi_a    <= '0;
`ifdef SPI_TX_MISO_EN
      rx_shift <= '0;
      rx_data  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          if (start) begin
            state    <= SETUP;
            shreg    <= tx_data;
            busy     <= 1'b1;
            spi_cs   <= 1'b0;
            spi_mosi <= tx_data[15];
            spi_a    <= tx_addr;
`ifdef SPI_TX_MISO_EN
            rx_shift <= '0;
`endif
          end
        end

        SETUP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= SHIFT;
            spi_clk <= 1'b1;
            bit_cnt <= 4'd15;
`ifdef SPI_TX_MISO_EN
            rx_shift <= {rx_shift[14:0], spi_miso};
`endif
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        // spi_clk itself tells which half of the bit period we are in.
        SHIFT: begin
          if (div_end) begin
            div_cnt <= '0;
            if (spi_clk) begin
              spi_clk <= 1'b0;
              // Next bit goes out on the falling edge; bit 0 stays put.
              if (bit_cnt != 4'd0) begin
                shreg    <= shreg << 1;
                spi_mosi <= shreg[14];
              end
            end else if (bit_cnt == 4'd0) begin
              state <= HOLD;
            end else begin
              spi_clk <= 1'b1;
              bit_cnt <= bit_cnt - 4'd1;
`ifdef SPI_TX_MISO_EN
              rx_shift <= {rx_shift[14:0], spi_miso};
`endif
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        HOLD: begin
          if (div_end) begin
            div_cnt  <= '0;
            state    <= GAP;
            spi_cs   <= 1'b1;
            spi_mosi <= 1'b0;
            spi_a    <= '0;
            // With a one-cycle GAP the first GAP cycle is also the last.
            if (DIV_LAST == 8'd0) begin
              done <= 1'b1;
`ifdef SPI_TX_MISO_EN
              rx_data <= rx_shift;
`endif
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        GAP: begin
          if (div_end) begin
            div_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 8'd1;
            // Registered done lands on the final GAP cycle.
            if (div_cnt + 8'd1 == DIV_LAST) begin
              done <= 1'b1;
`ifdef SPI_TX_MISO_EN
              rx_data <= rx_shift;
`endif
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
